// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the core's
// data port. Each read or write request is accepted in IDLE and held for
// WAIT_STATES cycles. It then completes with a one-cycle dReady pulse. Bad
// addresses (out of window or misaligned) and read+write collisions complete
// with dError=1 and dReadData=0, and do not write storage.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   dAddress, dWriteData     byte address and store data
//   MemRead, MemWrite        request strobes, held until dReady
//   dByteEn                  byte write strobes (only with DMEM_BYTE_STROBE_EN)
//   dReadData                load data, held until next read/error/reset
//   dReady, dError           completion pulse and its error qualifier
//
// Optional build macro: DMEM_BYTE_STROBE_EN adds dByteEn for partial writes.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  dByteEn,
`endif
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dError
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the live request is used so a zero-wait access can complete on
  // its accept edge; later states only see the latched copy.
  logic        idle;
  logic [31:0] cur_addr, cur_data, off;
  logic        cur_rd, cur_wr, bad, enter_resp, mem_we;
  logic [3:0]  cur_be, in_be;
  logic [IDXW-1:0] idx;

`ifdef DMEM_BYTE_STROBE_EN
  assign in_be = dByteEn;
`else
  assign in_be = 4'b1111;
`endif

  assign idle     = (state_q == S_IDLE);
  assign cur_addr = idle ? dAddress   : addr_q;
  assign cur_data = idle ? dWriteData : data_q;
  assign cur_rd   = idle ? MemRead    : rd_q;
  assign cur_wr   = idle ? MemWrite   : wr_q;
  assign cur_be   = idle ? in_be      : be_q;

  // An address below BASE wraps to a huge offset, so one upper-bit test
  // covers both ends of the window. BASE is word aligned, so off[1:0]
  // carries the address alignment.
  assign off = cur_addr - BASE_ADDR;
  assign idx = off[IDXW+1:2];
  assign bad = (off[31:IDXW+2] != '0) || (off[1:0] != 2'b00) || (cur_rd && cur_wr);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    be_d       = be_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d = dAddress;
          data_d = dWriteData;
          rd_d   = MemRead;
          wr_d   = MemWrite;
          be_d   = in_be;
          cnt_d  = 4'd0;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WS_LAST) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) err_d = bad;
  end

  assign mem_we = enter_resp && cur_wr && !bad;

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp) begin
      if (bad)         rdata_d = 32'h0;
      else if (cur_rd) rdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is never reset; a reset edge suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (cur_be[b]) mem[idx][8*b +: 8] <= cur_data[8*b +: 8];
    end
  end

  assign dReady    = (state_q == S_RESP);
  assign dError    = dReady && err_q;
  assign dReadData = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic        mrd [3];
  logic        mwr [3];
  logic [3:0]  be [3];
  logic [31:0] rdata [3];
  logic        rdy [3];
  logic        err [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // instance 0: WAIT_STATES=0, 1: WAIT_STATES=1, 2: WAIT_STATES=3
  dmem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[0]), .dAddress(addr[0]), .dWriteData(wdata[0]),
    .MemRead(mrd[0]), .MemWrite(mwr[0]),
`ifdef DMEM_BYTE_STROBE_EN
    .dByteEn(be[0]),
`endif
    .dReadData(rdata[0]), .dReady(rdy[0]), .dError(err[0]));

  dmem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst[1]), .dAddress(addr[1]), .dWriteData(wdata[1]),
    .MemRead(mrd[1]), .MemWrite(mwr[1]),
`ifdef DMEM_BYTE_STROBE_EN
    .dByteEn(be[1]),
`endif
    .dReadData(rdata[1]), .dReady(rdy[1]), .dError(err[1]));

  dmem_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst[2]), .dAddress(addr[2]), .dWriteData(wdata[2]),
    .MemRead(mrd[2]), .MemWrite(mwr[2]),
`ifdef DMEM_BYTE_STROBE_EN
    .dByteEn(be[2]),
`endif
    .dReadData(rdata[2]), .dReady(rdy[2]), .dError(err[2]));

  // Drives one access and reports latency (cycles until dReady, -1 on
  // timeout), the response, and dReady one cycle after the pulse.
  task automatic access(input int d, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, output int lat,
                        output logic [31:0] rd_o, output logic er_o,
                        output logic rdy_after);
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; mrd[d] = r; mwr[d] = w; be[d] = b;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy[d]) begin lat = i; break; end
    end
    rd_o = rdata[d]; er_o = err[d];
    mrd[d] = 1'b0; mwr[d] = 1'b0;
    @(posedge clk); #1;
    rdy_after = rdy[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; addr[d] = '0; wdata[d] = '0; mrd[d] = 0; mwr[d] = 0; be[d] = 4'hF;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      n_chk++; if (rdy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_dReady[%0d] got %b want 0", d, rdy[d]); end
      n_chk++; if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_dError[%0d] got %b want 0", d, err[d]); end
      n_chk++; if (rdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_dReadData[%0d] got %h want 0", d, rdata[d]); end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er, ra;
    access(1, 0, 1, 32'h10010004, 32'hCAFEF00D, 4'hF, lat, rd, er, ra);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency got %0d want 2", lat); end
    n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_dError got %b want 0", er); end
    n_chk++; if (ra !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_width dReady after pulse %b want 0", ra); end
    access(1, 1, 0, 32'h10010004, 32'h0, 4'hF, lat, rd, er, ra);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency got %0d want 2", lat); end
    n_chk++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_data got %h want cafef00d", rd); end
    n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_dError got %b want 0", er); end
    // a write does not disturb the held load data
    access(1, 0, 1, 32'h10010008, 32'h0, 4'hF, lat, rd, er, ra);
    n_chk++; if (rdata[1] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rdata_hold got %h want cafef00d", rdata[1]); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er, ra;
    access(0, 0, 1, 32'h10010000, 32'h11111111, 4'hF, lat, rd, er, ra);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_wr_latency got %0d want 1", lat); end
    access(0, 1, 0, 32'h10010000, 32'h0, 4'hF, lat, rd, er, ra);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_rd_latency got %0d want 1", lat); end
    n_chk++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL b2b_rd_data got %h want 11111111", rd); end
    n_chk++; if (ra !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_width dReady after pulse %b want 0", ra); end
    // last word of the window
    access(0, 0, 1, 32'h100103FC, 32'h22222222, 4'hF, lat, rd, er, ra);
    access(0, 1, 0, 32'h100103FC, 32'h0, 4'hF, lat, rd, er, ra);
    n_chk++; if (rd !== 32'h22222222 || er !== 1'b0) begin n_fail++; $display("FAIL last_word got %h err %b want 22222222 err 0", rd, er); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, ra;
    logic [31:0] ea [4];
    logic        ew [4];
    ea[0] = 32'h10010002; ew[0] = 0;   // misaligned
    ea[1] = 32'h10010400; ew[1] = 0;   // one past end
    ea[2] = 32'h10010000; ew[2] = 1;   // read and write together
    ea[3] = 32'h1000FFFC; ew[3] = 0;   // just below base
    access(1, 0, 1, 32'h10010000, 32'h12345678, 4'hF, lat, rd, er, ra);
    for (int i = 0; i < 4; i++) begin
      access(1, 1, ew[i], ea[i], 32'hDEADBEEF, 4'hF, lat, rd, er, ra);
      n_chk++; if (lat !== 2 || er !== 1'b1) begin n_fail++; $display("FAIL err_flag[%0d] lat %0d err %b want lat 2 err 1", i, lat, er); end
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_rdata[%0d] got %h want 0", i, rd); end
    end
    access(1, 1, 0, 32'h10010000, 32'h0, 4'hF, lat, rd, er, ra);
    n_chk++; if (rd !== 32'h12345678 || er !== 1'b0) begin n_fail++; $display("FAIL err_no_write got %h err %b want 12345678 err 0", rd, er); end
  endtask

  task automatic test_mid_reset();
    int lat; logic [31:0] rd; logic er, ra;
    access(2, 0, 1, 32'h10010008, 32'h0, 4'hF, lat, rd, er, ra);
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL ws3_latency got %0d want 4", lat); end
    access(2, 1, 0, 32'h10010008, 32'h0, 4'hF, lat, rd, er, ra);
    @(negedge clk);
    addr[2] = 32'h10010008; wdata[2] = 32'hA5A5A5A5; mwr[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[2] = 1'b1; #1;
    n_chk++; if (rdy[2] !== 1'b0 || err[2] !== 1'b0 || rdata[2] !== 32'h0) begin
      n_fail++; $display("FAIL midrst_outputs rdy %b err %b rdata %h want 0 0 0", rdy[2], err[2], rdata[2]);
    end
    mwr[2] = 1'b0;
    @(negedge clk); rst[2] = 1'b0;
    access(2, 1, 0, 32'h10010008, 32'h0, 4'hF, lat, rd, er, ra);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_no_write got %h want 0", rd); end
  endtask

  task automatic test_held();
    int lat; logic [31:0] rd; logic er, ra;
    access(2, 0, 1, 32'h10010014, 32'h55555555, 4'hF, lat, rd, er, ra);
    access(2, 0, 1, 32'h10010018, 32'h66666666, 4'hF, lat, rd, er, ra);
    @(negedge clk);
    addr[2] = 32'h10010014; mrd[2] = 1'b1;
    @(posedge clk); #1;
    addr[2] = 32'h10010018; mwr[2] = 1'b1;   // garbage after accept
    lat = -1;
    for (int i = 2; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy[2]) begin lat = i; break; end
    end
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL held_latency got %0d want 4", lat); end
    n_chk++; if (rdata[2] !== 32'h55555555 || err[2] !== 1'b0) begin
      n_fail++; $display("FAIL held_data got %h err %b want 55555555 err 0", rdata[2], err[2]);
    end
    mrd[2] = 1'b0; mwr[2] = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (rdy[2] !== 1'b0) begin n_fail++; $display("FAIL held_pulse_width got %b want 0", rdy[2]); end
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_byte_strobe();
    int lat; logic [31:0] rd; logic er, ra;
    access(1, 0, 1, 32'h1001000C, 32'h00000000, 4'hF, lat, rd, er, ra);
    access(1, 0, 1, 32'h1001000C, 32'hAABBCCDD, 4'b0101, lat, rd, er, ra);
    access(1, 1, 0, 32'h1001000C, 32'h0, 4'h0, lat, rd, er, ra);
    n_chk++; if (rd !== 32'h00BB00DD) begin n_fail++; $display("FAIL strobe_0101 got %h want 00bb00dd", rd); end
    access(1, 0, 1, 32'h1001000C, 32'hFFFFFFFF, 4'b0000, lat, rd, er, ra);
    n_chk++; if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL strobe_0000_done lat %0d err %b want 2 0", lat, er); end
    access(1, 1, 0, 32'h1001000C, 32'h0, 4'h0, lat, rd, er, ra);
    n_chk++; if (rd !== 32'h00BB00DD) begin n_fail++; $display("FAIL strobe_0000 got %h want 00bb00dd", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_mid_reset();
    test_held();
`ifdef DMEM_BYTE_STROBE_EN
    test_byte_strobe();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
